// File: rtl/bus_cache.sv
// bus_cache: direct-mapped, one-word-per-line, write-through, no-write-allocate
// cache between the CPU memory bus and a backing memory with the same handshake.
// Hits return in one cycle. Read misses fill a line. Every write goes to memory.
// A whole-cache invalidate and saturating hit/miss counters are also provided.
module bus_cache #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      data_in,
  input  logic             mem_wr,
  input  logic             mem_re,
  output logic [31:0]      data_out,
  output logic             mem_ready,
  input  logic             inv,
  output logic [31:0]      ext_addr,
  output logic [31:0]      ext_data_in,
  input  logic [31:0]      ext_data_out,
  output logic             ext_wr,
  output logic             ext_re,
  input  logic             ext_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] lineValid_q, lineValid_d;
  logic [TAG_W-1:0] tagArr_q  [LINES];
  logic [31:0]      dataArr_q [LINES];

  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      dout_q, dout_d;
  logic [CNT_W-1:0] hitCnt_q, hitCnt_d;
  logic [CNT_W-1:0] missCnt_q, missCnt_d;

  logic                  lineWe;
  logic [INDEX_BITS-1:0] lineIdx;
  logic [TAG_W-1:0]      lineTag;
  logic [31:0]           lineData;

  logic [INDEX_BITS-1:0] reqIdx, latchIdx;
  logic [TAG_W-1:0]      reqTag, latchTag;
  logic                  reqHit;

  assign reqIdx   = addr[INDEX_BITS+1:2];
  assign reqTag   = addr[31:INDEX_BITS+2];
  assign latchIdx = addr_q[INDEX_BITS+1:2];
  assign latchTag = addr_q[31:INDEX_BITS+2];
  assign reqHit   = lineValid_q[reqIdx] && (tagArr_q[reqIdx] == reqTag);

  // Next-state, datapath latching and line-update decisions for the controller
  always_comb begin
    state_d     = state_q;
    lineValid_d = lineValid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dout_d      = dout_q;
    hitCnt_d    = hitCnt_q;
    missCnt_d   = missCnt_q;
    lineWe      = 1'b0;
    lineIdx     = reqIdx;
    lineTag     = reqTag;
    lineData    = data_in;
    unique case (state_q)
      IDLE: begin
        if (inv) begin
          lineValid_d = '0;
        end else if (mem_wr) begin
          addr_d  = addr;
          wdata_d = data_in;
          lineWe  = reqHit;
          state_d = WRITE;
        end else if (mem_re && reqHit) begin
          dout_d = dataArr_q[reqIdx];
          if (hitCnt_q != {CNT_W{1'b1}}) hitCnt_d = hitCnt_q + 1'b1;
          state_d = RESP;
        end else if (mem_re) begin
          addr_d = addr;
          if (missCnt_q != {CNT_W{1'b1}}) missCnt_d = missCnt_q + 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (ext_ready) begin
          lineWe               = 1'b1;
          lineIdx              = latchIdx;
          lineTag              = latchTag;
          lineData             = ext_data_out;
          lineValid_d[latchIdx] = 1'b1;
          dout_d               = ext_data_out;
          state_d              = RESP;
        end
      end
      WRITE: begin
        if (ext_ready) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lineValid_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
      hitCnt_q    <= '0;
      missCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lineValid_q <= lineValid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dout_q      <= dout_d;
      hitCnt_q    <= hitCnt_d;
      missCnt_q   <= missCnt_d;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (!rst && lineWe) begin
      tagArr_q[lineIdx]  <= lineTag;
      dataArr_q[lineIdx] <= lineData;
    end
  end

  assign mem_ready   = (state_q == RESP);
  assign ext_re      = (state_q == FILL);
  assign ext_wr      = (state_q == WRITE);
  assign ext_addr    = addr_q & 32'hFFFF_FFFC;
  assign ext_data_in = wdata_q;
  assign data_out    = dout_q;
  assign hit_count   = hitCnt_q;
  assign miss_count  = missCnt_q;

endmodule

// File: tb/tb_bus_cache.sv
// tb_bus_cache: directed test of bus_cache. Stimulus pushes the expected read
// data for each request into a scoreboard queue; a monitor pops and compares
// whenever the cache presents mem_ready.
module tb_bus_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, data_in, data_out;
  logic        mem_wr, mem_re, mem_ready, inv;
  logic [31:0] ext_addr, ext_data_in, ext_data_out;
  logic        ext_wr, ext_re, ext_ready;
  logic [15:0] hit_count, miss_count;

  int tests = 0;
  int fails = 0;
  logic [31:0] expQ[$];

  bus_cache #(.INDEX_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .mem_wr(mem_wr), .mem_re(mem_re), .data_out(data_out),
    .mem_ready(mem_ready), .inv(inv), .ext_addr(ext_addr),
    .ext_data_in(ext_data_in), .ext_data_out(ext_data_out),
    .ext_wr(ext_wr), .ext_re(ext_re), .ext_ready(ext_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (mem_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected mem_ready", 32'd1, 32'd0);
      end else begin
        checkOutput("data_out", data_out, expQ.pop_front());
      end
    end
  end

  // One CPU request with a memory responder that answers after lat ext cycles
  task automatic applyStimulus(input string name, input logic re, input logic we,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic doInv, input int lat, input logic [31:0] memData,
                               input int expRe, input int expWr, input int expCycle,
                               input int expHit, input int expMiss, input logic [31:0] expData);
    int reCnt = 0;
    int wrCnt = 0;
    int doneAt = -1;
    expQ.push_back(expData);
    @(posedge clk); #1;
    addr = a; data_in = d; mem_re = re; mem_wr = we; inv = doInv;
    for (int cyc = 0; cyc < 30 && doneAt < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) inv = 1'b0;
      if (ext_re) begin
        reCnt++;
        if (reCnt == 1) checkOutput({name, " ext_addr rd"}, ext_addr, {a[31:2], 2'b00});
      end
      if (ext_wr) begin
        wrCnt++;
        if (wrCnt == 1) begin
          checkOutput({name, " ext_addr wr"}, ext_addr, {a[31:2], 2'b00});
          checkOutput({name, " ext_data_in"}, ext_data_in, d);
        end
      end
      ext_data_out = memData;
      ext_ready = (ext_re || ext_wr) && ((reCnt + wrCnt) == lat);
      if (mem_ready) begin
        doneAt = cyc;
        mem_re = 1'b0; mem_wr = 1'b0;
      end
    end
    if (doneAt < 0) begin
      checkOutput({name, " timeout"}, 32'd0, 32'd1);
      mem_re = 1'b0; mem_wr = 1'b0; ext_ready = 1'b0; inv = 1'b0;
    end
    checkOutput({name, " ext_re cycles"}, reCnt, expRe);
    checkOutput({name, " ext_wr cycles"}, wrCnt, expWr);
    checkOutput({name, " latency"}, doneAt, expCycle);
    checkOutput({name, " hit_count"}, {16'd0, hit_count}, expHit);
    checkOutput({name, " miss_count"}, {16'd0, miss_count}, expMiss);
  endtask

  initial begin
    rst = 1'b1; addr = '0; data_in = '0; mem_wr = 1'b0; mem_re = 1'b0;
    inv = 1'b0; ext_data_out = '0; ext_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset mem_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("reset ext_re/wr", {30'd0, ext_re, ext_wr}, 32'd0);
    checkOutput("reset data_out", data_out, 32'd0);
    checkOutput("reset ext_addr", ext_addr, 32'd0);
    checkOutput("reset counters", {hit_count, miss_count}, 32'd0);
    rst = 1'b0;

    // name re we addr data inv lat memData expRe expWr expCycle hit miss expData
    applyStimulus("miss 0x100", 1, 0, 32'h100, 32'h0, 0, 2, 32'hDEADBEEF, 2, 0, 3, 0, 1, 32'hDEADBEEF);
    applyStimulus("hit 0x100", 1, 0, 32'h100, 32'h0, 0, 1, 32'h0, 0, 0, 1, 1, 1, 32'hDEADBEEF);
    applyStimulus("miss 0x140", 1, 0, 32'h140, 32'h0, 0, 1, 32'h11111111, 1, 0, 2, 1, 2, 32'h11111111);
    applyStimulus("evicted 0x100", 1, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1, 0, 2, 1, 3, 32'hDEADBEEF);
    applyStimulus("write hit 0x100", 0, 1, 32'h100, 32'hCAFEF00D, 0, 2, 32'h0, 0, 2, 3, 1, 3, 32'hDEADBEEF);
    applyStimulus("hit after wr", 1, 0, 32'h100, 32'h0, 0, 1, 32'h0, 0, 0, 1, 2, 3, 32'hCAFEF00D);
    applyStimulus("write miss 0x200", 0, 1, 32'h200, 32'h12345678, 0, 1, 32'h0, 0, 1, 2, 2, 3, 32'hCAFEF00D);
    applyStimulus("no-alloc 0x200", 1, 0, 32'h200, 32'h0, 0, 1, 32'h12345678, 1, 0, 2, 2, 4, 32'h12345678);
    applyStimulus("re+wr 0x104", 1, 1, 32'h104, 32'hA5A5A5A5, 0, 1, 32'h0, 0, 1, 2, 2, 4, 32'h12345678);
    applyStimulus("refill 0x100", 1, 0, 32'h100, 32'h0, 0, 1, 32'hCAFEF00D, 1, 0, 2, 2, 5, 32'hCAFEF00D);
    applyStimulus("inv + read", 1, 0, 32'h100, 32'h0, 1, 1, 32'hCAFEF00D, 1, 0, 3, 2, 6, 32'hCAFEF00D);

    // Reset in the second FILL cycle abandons the miss
    @(posedge clk); #1;
    addr = 32'h180; mem_re = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("fill before rst", {31'd0, ext_re}, 32'd1);
    rst = 1'b1; mem_re = 1'b0;
    @(negedge clk);
    checkOutput("rst ext_re", {31'd0, ext_re}, 32'd0);
    checkOutput("rst mem_ready", {31'd0, mem_ready}, 32'd0);
    checkOutput("rst counters", {hit_count, miss_count}, 32'd0);
    rst = 1'b0;
    applyStimulus("after rst 0x180", 1, 0, 32'h180, 32'h0, 0, 1, 32'h0BADCAFE, 1, 0, 2, 0, 1, 32'h0BADCAFE);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
